// File: rtl/io_input_conditioner.sv
// Two-flop synchronizer, shared-tick debouncer, key press detection and count, packed into two 32-bit input words.
// Latency: 2 sync edges plus STABLE tick edges to a level change; no backpressure, outputs are free-running registers.
module io_input_conditioner #(
    parameter int SW_W     = 32,
    parameter int KEYS     = 4,
    parameter int TICK_DIV = 50000,
    parameter int STABLE   = 3
) (
    input  logic              io_clk,
    input  logic              reset,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic [KEYS-1:0]   key_raw,
    output logic [31:0]       in_port0,
    output logic [31:0]       in_port1,
    output logic [KEYS-1:0]   key_rise,
    output logic              tick
);

    localparam int N  = SW_W + KEYS;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Switches occupy the low SW_W bits of every per-pin vector, keys the top KEYS bits.
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [N-1:0]                s1_q, s2_q;
    logic [N-1:0]                level_q, level_d;
    logic [N-1:0][STABLE-2:0]    hist_q, hist_d;
    logic [KEYS-1:0]             rise_q, rise_d;
    logic [15:0]                 count_q, count_d;
    logic [15:0]                 inc;
    logic [STABLE-1:0]           cand;

    always_comb begin
        tick    = (cnt_q == CW'(TICK_DIV - 1));
        cnt_d   = tick ? '0 : cnt_q + CW'(1);
        hist_d  = hist_q;
        level_d = level_q;
        cand    = '0;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                cand      = {hist_q[i], s2_q[i]};
                hist_d[i] = cand[STABLE-2:0];
                if (&cand) begin
                    level_d[i] = 1'b1;
                end else if (!(|cand)) begin
                    level_d[i] = 1'b0;
                end
            end
        end
        rise_d = tick ? (level_d[N-1:SW_W] & ~level_q[N-1:SW_W]) : '0;
        inc    = '0;
        for (int k = 0; k < KEYS; k++) begin
            inc = inc + {15'd0, rise_d[k]};
        end
        count_d = count_q + inc;
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            hist_q  <= '0;
            level_q <= '0;
            rise_q  <= '0;
            count_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            s1_q    <= {key_raw, sw_raw};
            s2_q    <= s1_q;
            hist_q  <= hist_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        in_port0             = 32'(level_q[SW_W-1:0]);
        in_port1             = '0;
        in_port1[31:16]      = count_q;
        in_port1[KEYS-1:0]   = level_q[N-1:SW_W];
    end

    assign key_rise = rise_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: run-length reference model feeds a per-tick scoreboard, plus directed scenario checks.
module tb_io_input_conditioner;

    localparam int SW_W = 32;
    localparam int KEYS = 4;
    localparam int TD   = 4;
    localparam int ST   = 3;
    localparam int N    = SW_W + KEYS;

    logic              clk;
    logic              reset;
    logic [SW_W-1:0]   sw_raw;
    logic [KEYS-1:0]   key_raw;
    logic [31:0]       in_port0;
    logic [31:0]       in_port1;
    logic [KEYS-1:0]   key_rise;
    logic              tick;

    io_input_conditioner #(.SW_W(SW_W), .KEYS(KEYS), .TICK_DIV(TD), .STABLE(ST)) dut (
        .io_clk   (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .key_raw  (key_raw),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .key_rise (key_rise),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [3:0]  rise;
    } exp_t;

    exp_t        sbq[$];
    int          n_chk = 0;
    int          n_err = 0;

    // Reference model state: per-pin run of identical samples, plus the bench's own edge index.
    bit [N-1:0]  rawq[$];
    bit [N-1:0]  run_val;
    bit [N-1:0]  lvl_m;
    int          run_len[N];
    logic [15:0] cnt_m;
    int          e;

    logic [31:0] last0, last1;
    bit          pend;
    int          pend_e, mon_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        bit [N-1:0] s2, old;
        bit [3:0]   rise;
        exp_t       x;
        forever begin
            @(negedge clk);
            if (reset) begin
                rawq.delete();
                rawq.push_back('0);
                rawq.push_back('0);
                sbq.delete();
                e       = 0;
                run_val = '0;
                lvl_m   = '0;
                cnt_m   = '0;
                for (int i = 0; i < N; i++) run_len[i] = ST - 1;
            end else begin
                rawq.push_back({key_raw, sw_raw});
                s2 = rawq.pop_front();
                if (e % TD == TD - 1) begin
                    old = lvl_m;
                    for (int i = 0; i < N; i++) begin
                        if (s2[i] == run_val[i]) begin
                            if (run_len[i] < ST) run_len[i]++;
                        end else begin
                            run_val[i] = s2[i];
                            run_len[i] = 1;
                        end
                        if (run_len[i] >= ST) lvl_m[i] = run_val[i];
                    end
                    rise   = lvl_m[N-1:SW_W] & ~old[N-1:SW_W];
                    cnt_m  = cnt_m + 16'($countones(rise));
                    x.e    = e;
                    x.p0   = lvl_m[SW_W-1:0];
                    x.p1   = {cnt_m, 12'd0, lvl_m[N-1:SW_W]};
                    x.rise = rise;
                    sbq.push_back(x);
                end
                e++;
            end
        end
    end

    initial begin
        exp_t x;
        pend  = 1'b0;
        mon_e = 0;
        last0 = '0;
        last1 = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_port0", in_port0, 32'd0);
                chk("rst_port1", in_port1, 32'd0);
                chk("rst_rise", {28'd0, key_rise}, 32'd0);
                chk("rst_tick", {31'd0, tick}, 32'd0);
                pend  = 1'b0;
                mon_e = 0;
                last0 = '0;
                last1 = '0;
            end else begin
                if (pend) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL sb_underflow: tick at cycle %0d with no expected update", pend_e);
                    end else begin
                        x = sbq.pop_front();
                        chk("tick_cycle", pend_e, x.e);
                        chk("upd_port0", in_port0, x.p0);
                        chk("upd_port1", in_port1, x.p1);
                        chk("upd_rise", {28'd0, key_rise}, {28'd0, x.rise});
                        last0 = x.p0;
                        last1 = x.p1;
                    end
                end else begin
                    chk("idle_rise", {28'd0, key_rise}, 32'd0);
                    chk("hold_port0", in_port0, last0);
                    chk("hold_port1", in_port1, last1);
                end
                pend   = tick;
                pend_e = mon_e;
                mon_e++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait until the next edge index has the given phase within the tick period.
    task automatic align(input int ph);
        for (int i = 0; i < TD && (e % TD) != ph; i++) cyc(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        sw_raw  = '0;
        key_raw = '0;
        #1 reset = 1'b1;
        cyc(3);
        sw_raw = 32'h0000_00A5;
        reset  = 1'b0;
        cyc(24);
        chk("sw_a5", in_port0, 32'h0000_00A5);

        align(1);
        key_raw = 4'b0001;
        cyc(2);
        key_raw = 4'b0000;
        cyc(16);
        chk("glitch_port1", in_port1, 32'h0000_0000);

        align($urandom_range(0, TD - 1));
        key_raw = 4'b0101;
        cyc(20);
        chk("press_0101", in_port1, 32'h0002_0005);
        key_raw = 4'b0000;
        cyc(20);
        chk("release_0101", in_port1, 32'h0002_0000);

        align(2);
        force dut.count_q = 16'hFFFE;
        cnt_m = 16'hFFFE;
        last1 = {16'hFFFE, last1[15:0]};
        cyc(1);
        release dut.count_q;
        key_raw = 4'b0010;
        cyc(16);
        chk("count_ffff", in_port1, 32'hFFFF_0002);
        key_raw = 4'b0000;
        cyc(16);
        key_raw = 4'b0010;
        cyc(16);
        key_raw = 4'b0000;
        cyc(16);
        chk("count_wrap", in_port1, 32'h0000_0000);

        align(0);
        key_raw = 4'b0100;
        cyc(9);
        reset = 1'b1;
        #1;
        chk("midrst_port0", in_port0, 32'd0);
        chk("midrst_port1", in_port1, 32'd0);
        chk("midrst_rise", {28'd0, key_rise}, 32'd0);
        cyc(2);
        reset = 1'b0;
        cyc(16);
        chk("key2_after_rst", in_port1, 32'h0001_0004);

        align(0);
        key_raw = 4'b1100;
        cyc(4);
        key_raw = 4'b0100;
        cyc(4);
        key_raw = 4'b1100;
        cyc(20);
        chk("chatter", in_port1, 32'h0002_000C);
        key_raw = 4'b0000;
        cyc(20);

        repeat (300) begin
            sw_raw  = $urandom;
            key_raw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                cyc(2);
                reset = 1'b0;
            end
            cyc($urandom_range(1, 14));
        end
        cyc(20);
        align(2);
        chk("sb_drain", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
